// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: VGA timing generator with a selectable pixel-rate divider.
//
// Ports:
//   clk_in      system clock
//   reset       asynchronous, active-high reset
//   enable      run control; low freezes every register and gates pix_tick
//   div_sel     pixel rate: 00=/1, 01=/2, 10=/4, 11=/8 of clk_in
//   pix_tick    one-clk_in-cycle pixel strobe
//   hsync/vsync sync outputs, active level set by SYNC_ACTIVE_LOW
//   video_on    high while (x, y) lies in the visible area
//   x, y        current pixel position
//   frame_start (only with VGA_FRAME_PULSE_EN defined) one-cycle pulse when
//               the position becomes (0,0)
//
// Optional feature macro: VGA_FRAME_PULSE_EN adds the frame_start output.
//
// Horizontal FSM (vertical is identical on y, stepping only on x wrap):
//   state  | meaning
//   HS_ACT | visible pixels
//   HS_FP  | front porch
//   HS_SYN | sync pulse
//   HS_BP  | back porch (also the reset state, so the first pixel is (0,0))
module vga_sync_ctrl #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] div_sel,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y
`ifdef VGA_FRAME_PULSE_EN
  ,
  output logic       frame_start
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] X_FP_START = 10'(H_VISIBLE);
  localparam logic [9:0] X_SY_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] X_BP_START = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] Y_FP_START = 10'(V_VISIBLE);
  localparam logic [9:0] Y_SY_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] Y_BP_START = 10'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = ~SYNC_ACTIVE_LOW;
  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYN, HS_BP} h_state_t;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYN, VS_BP} v_state_t;

  h_state_t   h_state, h_next;
  v_state_t   v_state, v_next;
  logic [2:0] div_cnt;
  logic [2:0] div_max;
  logic [1:0] ratio_q;
  logic       tick_q;
  logic       div_wrap;
  logic       advance;
  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;

  // ratio_q only changes at a divider wrap, so a div_sel change mid-period
  // never shortens or merges a tick.
  always_comb begin
    div_max = 3'd0;
    unique case (ratio_q)
      2'b00: div_max = 3'd0;
      2'b01: div_max = 3'd1;
      2'b10: div_max = 3'd3;
      2'b11: div_max = 3'd7;
    endcase
  end

  assign div_wrap = (div_cnt == div_max);
  // The strobe register is held while disabled so no pending pixel is lost;
  // gating with enable keeps pix_tick low during the freeze.
  assign pix_tick = tick_q & enable;
  assign advance  = tick_q & enable;
  assign x_wrap   = (x == X_LAST);
  assign y_wrap   = (y == Y_LAST);
  assign x_next   = x_wrap ? 10'd0 : x + 10'd1;
  assign y_next   = x_wrap ? (y_wrap ? 10'd0 : y + 10'd1) : y;

  always_comb begin
    h_next = h_state;
    v_next = v_state;
    if (advance) begin
      unique case (h_state)
        HS_ACT: if (x_next == X_FP_START) h_next = HS_FP;
        HS_FP:  if (x_next == X_SY_START) h_next = HS_SYN;
        HS_SYN: if (x_next == X_BP_START) h_next = HS_BP;
        HS_BP:  if (x_next == 10'd0)      h_next = HS_ACT;
      endcase
      if (x_wrap) begin
        unique case (v_state)
          VS_ACT: if (y_next == Y_FP_START) v_next = VS_FP;
          VS_FP:  if (y_next == Y_SY_START) v_next = VS_SYN;
          VS_SYN: if (y_next == Y_BP_START) v_next = VS_BP;
          VS_BP:  if (y_next == 10'd0)      v_next = VS_ACT;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      h_state <= HS_BP;
      v_state <= VS_BP;
    end else if (enable) begin
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  // Sync and video_on are registered from the next states so they describe
  // the same pixel as x/y on every edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_cnt  <= 3'd0;
      ratio_q  <= 2'b00;
      tick_q   <= 1'b0;
      x        <= X_LAST;
      y        <= Y_LAST;
      hsync    <= SYNC_OFF;
      vsync    <= SYNC_OFF;
      video_on <= 1'b0;
    end else if (enable) begin
      if (div_wrap) begin
        div_cnt <= 3'd0;
        ratio_q <= div_sel;
        tick_q  <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 3'd1;
        tick_q  <= 1'b0;
      end
      if (advance) begin
        x <= x_next;
        y <= y_next;
      end
      hsync    <= (h_next == HS_SYN) ? SYNC_ON : SYNC_OFF;
      vsync    <= (v_next == VS_SYN) ? SYNC_ON : SYNC_OFF;
      video_on <= (h_next == HS_ACT) && (v_next == VS_ACT);
    end
  end

`ifdef VGA_FRAME_PULSE_EN
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else if (enable) begin
      frame_start <= advance & x_wrap & y_wrap;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Testbench for vga_sync_ctrl: a small-geometry instance and a default
// 640x480 instance share all inputs; a position-counter reference model
// predicts both every cycle, plus a vector table and directed sequences.
module tb_vga_sync_ctrl;

  localparam int SHV = 16, SHF = 2, SHS = 3, SHB = 4;
  localparam int SVV = 6,  SVF = 2, SVS = 2, SVB = 3;
  localparam int S_TOT = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);
  localparam int D_TOT = 800 * 525;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] div_sel = 2'b00;

  logic       s_tick, s_hsync, s_vsync, s_video;
  logic [9:0] s_x, s_y;
  logic       d_tick, d_hsync, d_vsync, d_video;
  logic [9:0] d_x, d_y;
`ifdef VGA_FRAME_PULSE_EN
  logic       s_fs, d_fs;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  vga_sync_ctrl #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) u_small (
    .clk_in(clk_in), .reset(reset), .enable(enable), .div_sel(div_sel),
    .pix_tick(s_tick), .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video),
    .x(s_x), .y(s_y)
`ifdef VGA_FRAME_PULSE_EN
    , .frame_start(s_fs)
`endif
  );

  vga_sync_ctrl u_def (
    .clk_in(clk_in), .reset(reset), .enable(enable), .div_sel(div_sel),
    .pix_tick(d_tick), .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video),
    .x(d_x), .y(d_y)
`ifdef VGA_FRAME_PULSE_EN
    , .frame_start(d_fs)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Expected {x, y, hsync, vsync, video_on} for linear pixel index pos.
  function automatic logic [22:0] exp_out(input int pos, input int hv, input int hf,
                                          input int hs, input int hb, input int vv,
                                          input int vf, input int vs, input int vb);
    int ht, xx, yy;
    logic ha, va, vid;
    ht  = hv + hf + hs + hb;
    xx  = pos % ht;
    yy  = pos / ht;
    ha  = (xx >= hv + hf) && (xx < hv + hf + hs);
    va  = (yy >= vv + vf) && (yy < vv + vf + vs);
    vid = (xx < hv) && (yy < vv);
    return {xx[9:0], yy[9:0], ~ha, ~va, vid};
  endfunction

  // Reference model: a tick is produced every 2^div_sel enabled cycles, with
  // div_sel taken at the previous tick; each tick steps a frame pixel index.
  int   m_left, m_pos_s, m_pos_d;
  logic m_tick, m_fs_s, m_fs_d;

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      m_left  = 1;
      m_tick  = 1'b0;
      m_pos_s = S_TOT - 1;
      m_pos_d = D_TOT - 1;
      m_fs_s  = 1'b0;
      m_fs_d  = 1'b0;
    end else if (enable) begin
      if (m_tick) begin
        m_pos_s = (m_pos_s + 1) % S_TOT;
        m_pos_d = (m_pos_d + 1) % D_TOT;
        m_fs_s  = (m_pos_s == 0);
        m_fs_d  = (m_pos_d == 0);
      end else begin
        m_fs_s = 1'b0;
        m_fs_d = 1'b0;
      end
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_tick = 1'b1;
        m_left = 1 << div_sel;
      end else begin
        m_tick = 1'b0;
      end
    end
  end

  always @(negedge clk_in) begin
    if (!reset) begin
      chk("small_out", {9'd0, s_x, s_y, s_hsync, s_vsync, s_video},
          {9'd0, exp_out(m_pos_s, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB)});
      chk("def_out", {9'd0, d_x, d_y, d_hsync, d_vsync, d_video},
          {9'd0, exp_out(m_pos_d, 640, 16, 96, 48, 480, 10, 2, 33)});
      chk("pix_tick", {30'd0, s_tick, d_tick}, {30'd0, m_tick & enable, m_tick & enable});
`ifdef VGA_FRAME_PULSE_EN
      chk("frame_start", {30'd0, s_fs, d_fs}, {30'd0, m_fs_s, m_fs_d});
`endif
    end
  end

  typedef struct {
    logic [1:0] sel;
    logic       en;
    int         ncyc;
    int         ex, ey;
    logic       evid, etick;
  } vec_t;

  vec_t vecs[11];

  task automatic do_reset();
    @(negedge clk_in);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk_in);
    #1 reset = 1'b0;
  endtask

  initial begin
    int gaps[3];
    int c, ng, cyc, hs_cnt, hs_first, hs_last;
    bit found;
    logic [9:0] prev_x;

    // Small geometry: H_TOTAL=25, V_TOTAL=13; sequence from reset release.
    vecs[0]  = '{2'd0, 1'b1, 1, 24, 12, 1'b0, 1'b1};
    vecs[1]  = '{2'd0, 1'b1, 1, 0, 0, 1'b1, 1'b1};
    vecs[2]  = '{2'd0, 1'b1, 10, 10, 0, 1'b1, 1'b1};
    vecs[3]  = '{2'd1, 1'b1, 4, 13, 0, 1'b1, 1'b0};
    vecs[4]  = '{2'd1, 1'b0, 5, 13, 0, 1'b1, 1'b0};
    vecs[5]  = '{2'd1, 1'b1, 2, 14, 0, 1'b1, 1'b0};
    vecs[6]  = '{2'd3, 1'b1, 3, 15, 0, 1'b1, 1'b0};
    vecs[7]  = '{2'd3, 1'b1, 8, 16, 0, 1'b0, 1'b0};
    vecs[8]  = '{2'd3, 1'b1, 5, 16, 0, 1'b0, 1'b0};
    vecs[9]  = '{2'd0, 1'b1, 1, 16, 0, 1'b0, 1'b1};
    vecs[10] = '{2'd0, 1'b1, 9, 0, 1, 1'b1, 1'b1};

    #1 reset = 1'b1;
    do_reset();

    for (int i = 0; i < 11; i++) begin
      div_sel = vecs[i].sel;
      enable  = vecs[i].en;
      repeat (vecs[i].ncyc) @(negedge clk_in);
      chk($sformatf("vec%0d_x", i), {22'd0, s_x}, vecs[i].ex[31:0]);
      chk($sformatf("vec%0d_y", i), {22'd0, s_y}, vecs[i].ey[31:0]);
      chk($sformatf("vec%0d_video", i), {31'd0, s_video}, {31'd0, vecs[i].evid});
      chk($sformatf("vec%0d_tick", i), {31'd0, s_tick}, {31'd0, vecs[i].etick});
      #1;
    end

    // Random run-control and rate changes against the model.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk_in);
      #1;
      if ($urandom_range(0, 15) == 0) div_sel = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 7) != 0);
    end

    // /8 on the default geometry: 6400-cycle line, hsync over x=656..751.
    div_sel = 2'd3;
    enable  = 1'b1;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      if (d_x == 10'd0) found = 1;
    end
    if (!found) timeout("line_start");
    cyc = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    prev_x = d_x;
    found = 0;
    for (int i = 0; i < 7000 && !found; i++) begin
      @(negedge clk_in);
      cyc++;
      if (d_x == 10'd0 && prev_x != 10'd0) found = 1;
      else if (d_tick && !d_hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_x);
        hs_last = int'(d_x);
      end
      prev_x = d_x;
    end
    if (!found) timeout("line_end");
    chk("line_period", cyc, 32'd6400);
    chk("hsync_ticks", hs_cnt, 32'd96);
    chk("hsync_first_x", hs_first, 32'd656);
    chk("hsync_last_x", hs_last, 32'd751);

    // Rate change 11 -> 01 at divide count 3: gaps must be 8, 2, 2.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      if (d_tick) found = 1;
    end
    if (!found) timeout("rate_tick");
    repeat (3) @(negedge clk_in);
    #1 div_sel = 2'd1;
    c = 3; ng = 0;
    for (int i = 0; i < 40 && ng < 3; i++) begin
      @(negedge clk_in);
      c++;
      if (d_tick) begin
        gaps[ng] = c;
        ng++;
        c = 0;
      end
    end
    if (ng < 3) timeout("rate_gaps");
    else begin
      chk("gap0", gaps[0], 32'd8);
      chk("gap1", gaps[1], 32'd2);
      chk("gap2", gaps[2], 32'd2);
    end

    // Freeze at (100,7) for 50 cycles, then resume to x=101.
    #1 div_sel = 2'd0;
    do_reset();
    found = 0;
    for (int i = 0; i < 8000 && !found; i++) begin
      @(negedge clk_in);
      if (d_x == 10'd100 && d_y == 10'd7) found = 1;
    end
    if (!found) timeout("reach_100_7");
    #1 enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      chk("freeze", {17'd0, d_x, d_y, d_tick, d_hsync, d_vsync, d_video},
          {17'd0, 10'd100, 10'd7, 1'b0, 1'b1, 1'b1, 1'b1});
    end
    #1 enable = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      if (d_x != 10'd100) found = 1;
    end
    if (!found) timeout("resume");
    chk("resume_xy", {12'd0, d_x, d_y}, {12'd0, 10'd101, 10'd7});

    // Reset pulse at x=700, then first tick lands on (0,0).
    do_reset();
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk_in);
      if (d_x == 10'd700) found = 1;
    end
    if (!found) timeout("reach_700");
    #1 reset = 1'b1;
    #1;
    chk("async_reset", {8'd0, d_x, d_y, d_tick, d_hsync, d_vsync, d_video},
        {8'd0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0});
    @(negedge clk_in);
    #1 reset = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_in);
      if (d_tick) found = 1;
    end
    if (!found) timeout("first_tick");
    @(negedge clk_in);
    chk("first_pixel", {11'd0, d_x, d_y, d_video}, {11'd0, 10'd0, 10'd0, 1'b1});
`ifdef VGA_FRAME_PULSE_EN
    chk("first_frame_start", {31'd0, d_fs}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back-porch pixels.
REQ-005 SHALL have parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33, as the vertical equivalents in lines.
REQ-006 SHALL have parameter SYNC_ACTIVE_LOW, default 1; 1 means hsync/vsync are low when active.
REQ-007 SHALL have port clk_in  input  1  system clock.
REQ-008 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port enable  input  1  run control; low freezes all state.
REQ-010 SHALL have port div_sel  input  2  pixel-rate select: 00=/1, 01=/2, 10=/4, 11=/8 of clk_in.
REQ-011 SHALL have port pix_tick  output  1  one-clk_in-cycle pixel strobe.
REQ-012 SHALL have ports hsync, vsync  output  1 each  sync outputs, polarity per SYNC_ACTIVE_LOW.
REQ-013 SHALL have port video_on  output  1  high while the current position is visible.
REQ-014 SHALL have ports x, y  output  10 each  current horizontal and vertical position.

Function
REQ-015 SHALL contain a 3-bit divide counter that increments each clk_in cycle while enable=1 and wraps at ratio-1; pix_tick SHALL be registered and high for exactly one cycle per wrap, giving a period of 1/2/4/8 clk_in cycles.
REQ-016 SHALL sample div_sel only when the divide counter wraps; a mid-period change SHALL take effect from the next period, with no short or merged tick.
REQ-017 SHALL advance x on every clk_in edge at which pix_tick=1; x SHALL wrap from H_TOTAL-1 to 0, where H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (800 by default).
REQ-018 SHALL advance y only when x wraps; y SHALL wrap from V_TOTAL-1 to 0, where V_TOTAL is the vertical sum (525 by default).
REQ-019 SHALL implement a horizontal FSM with states H_ACT -> H_FP -> H_SYN -> H_BP -> H_ACT, advancing when x crosses segment boundaries 0, H_VISIBLE, H_VISIBLE+H_FP and H_VISIBLE+H_FP+H_SYNC.
REQ-020 SHALL implement a vertical FSM with states V_ACT/V_FP/V_SYN/V_BP on the same boundaries in y, transitioning only on an x wrap.
REQ-021 SHALL register hsync, vsync and video_on on the same edge as x/y, so all outputs describe the same pixel with zero relative skew.
REQ-022 SHALL drive hsync active exactly in state H_SYN and vsync active exactly in state V_SYN; video_on SHALL equal (H_ACT and V_ACT).
REQ-023 SHALL, when enable=0, hold the divide counter, x, y, both FSMs and all outputs; pix_tick SHALL be 0. Resuming enable SHALL continue from the held count.
REQ-024 SHALL treat the simultaneous x wrap and y wrap as a single frame wrap to (0,0).

Reset
REQ-025 SHALL asynchronously set: divide counter=0, sampled ratio=/1, pix_tick=0, x=H_TOTAL-1, y=V_TOTAL-1, FSMs in H_BP/V_BP, hsync and vsync inactive, video_on=0.
REQ-026 SHALL make the first pix_tick after reset release move the position to (0,0) with video_on=1; reset asserted mid-line SHALL abort immediately to the REQ-025 values.

Configuration
REQ-027 SHALL use macro VGA_FRAME_PULSE_EN: when defined, add output port frame_start (1 bit) that pulses high for one clk_in cycle on the edge where the position becomes (0,0), and resets to 0; when undefined, the port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-028 Defaults, div_sel=11, enable=1 -> pix_tick every 8 clk_in cycles; line period 6400 cycles; hsync low for x=656..751 (96 ticks).
REQ-029 Defaults, div_sel=00 -> vsync low for exactly y=490..491 (1600 ticks); frame is 420000 ticks; video_on high for 307200 ticks per frame.
REQ-030 Switch div_sel from 11 to 01 at divide count 3 -> the current 8-cycle period completes, then the tick period is 2 cycles; no tick occurs fewer than 2 cycles after the prior tick.
REQ-031 enable=0 for 50 cycles at x=100, y=7 -> x, y and the outputs are unchanged and pix_tick=0; after release, x=101 on the next tick.
REQ-032 reset pulse at x=700 -> outputs immediately take the REQ-025 values; after release the first tick gives (0,0), video_on=1, and frame_start=1 when VGA_FRAME_PULSE_EN is defined.
